// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity modes and the
// parity helper used by both the transmitter and a parity-aware receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        PARITY_BIT = 3'd3,
        STOP       = 3'd4
    } uart_tx_state_t;

    localparam int UART_PARITY_NONE = 0;
    localparam int UART_PARITY_ODD  = 1;
    localparam int UART_PARITY_EVEN = 2;

    // Widest data word any UART in the codebase carries; narrower words are
    // zero-extended, which leaves the XOR reduction unchanged.
    localparam int UART_MAX_BITS = 9;

    // Parity bit to append for the given mode: odd makes the total count of
    // ones odd, even makes it even, none yields 0.
    function automatic logic uart_parity(input logic [UART_MAX_BITS-1:0] data,
                                         input int mode);
        logic result;
        case (mode)
            UART_PARITY_ODD:  result = ~(^data);
            UART_PARITY_EVEN: result = ^data;
            default:          result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: accepts one word per valid/ready handshake and sends it
// LSB first as start bit, data bits, optional parity bit and 1 or 2 stop
// bits on a registered, glitch-free tx line. Back-to-back words are sent
// without an idle gap by accepting the next word in the last stop cycle.
module uart_tx
    import uart_pkg::*;
#(
    parameter int NUMBER_OF_BITS = 8,
    parameter int BAUD_DIVIDER   = 4,
    parameter int PARITY         = 0,
    parameter int STOP_BITS      = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      data_valid,
    output logic                      data_ready,
    input  logic [NUMBER_OF_BITS-1:0] data_bits,
    output logic                      tx,
    output logic                      busy
);

    localparam int RATE_CLOG = $clog2(STOP_BITS * BAUD_DIVIDER);
    localparam int RATE_W    = (RATE_CLOG < 1) ? 1 : RATE_CLOG;
    localparam int BIT_CLOG  = $clog2(NUMBER_OF_BITS);
    localparam int BIT_W     = (BIT_CLOG < 1) ? 1 : BIT_CLOG;

    localparam logic [RATE_W-1:0] BAUD_RELOAD = RATE_W'(BAUD_DIVIDER - 1);
    localparam logic [RATE_W-1:0] STOP_RELOAD = RATE_W'(STOP_BITS * BAUD_DIVIDER - 1);
    localparam logic [BIT_W-1:0]  BIT_RELOAD  = BIT_W'(NUMBER_OF_BITS - 1);

    // Illegal parameter combinations stop elaboration.
    if (NUMBER_OF_BITS < 5 || NUMBER_OF_BITS > UART_MAX_BITS) begin : g_bad_bits
        $fatal(1, "uart_tx: NUMBER_OF_BITS must be 5..9");
    end
    if (BAUD_DIVIDER < 2) begin : g_bad_baud
        $fatal(1, "uart_tx: BAUD_DIVIDER must be at least 2");
    end
    if (PARITY < UART_PARITY_NONE || PARITY > UART_PARITY_EVEN) begin : g_bad_parity
        $fatal(1, "uart_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $fatal(1, "uart_tx: STOP_BITS must be 1 or 2");
    end

    uart_tx_state_t              state_q,    state_d;
    logic [RATE_W-1:0]           rate_q,     rate_d;
    logic [BIT_W-1:0]            bit_cnt_q,  bit_cnt_d;
    logic [NUMBER_OF_BITS-1:0]   shift_q,    shift_d;
    logic                        parity_q,   parity_d;
    logic                        tx_q,       tx_d;
    logic                        busy_q,     busy_d;

    logic                        rate_zero_s;
    logic                        ready_s;
    logic                        handshake_s;
    logic [UART_MAX_BITS-1:0]    par_data_s;

    // Handshake qualification: ready in IDLE or the final stop cycle, never in reset.
    always_comb begin
        par_data_s = {UART_MAX_BITS{1'b0}};
        par_data_s[NUMBER_OF_BITS-1:0] = data_bits;
        rate_zero_s = (rate_q == {RATE_W{1'b0}});
        if (reset) begin
            ready_s = 1'b0;
        end else if (state_q == IDLE) begin
            ready_s = 1'b1;
        end else if ((state_q == STOP) && rate_zero_s) begin
            ready_s = 1'b1;
        end else begin
            ready_s = 1'b0;
        end
        handshake_s = data_valid & ready_s;
    end

    // Next-state, counter, shift-register and line-level computation.
    always_comb begin
        state_d   = state_q;
        rate_d    = rate_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        tx_d      = tx_q;
        busy_d    = busy_q;

        case (state_q)
            IDLE: begin
                if (handshake_s) begin
                    state_d  = START;
                    rate_d   = BAUD_RELOAD;
                    shift_d  = data_bits;
                    parity_d = uart_parity(par_data_s, PARITY);
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
                end else begin
                    tx_d   = 1'b1;
                    busy_d = 1'b0;
                end
            end
            START: begin
                if (rate_zero_s) begin
                    state_d   = DATA;
                    rate_d    = BAUD_RELOAD;
                    bit_cnt_d = BIT_RELOAD;
                    tx_d      = shift_q[0];
                end else begin
                    rate_d = rate_q - RATE_W'(1);
                end
            end
            DATA: begin
                if (rate_zero_s) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == {BIT_W{1'b0}}) begin
                        if (PARITY != UART_PARITY_NONE) begin
                            state_d = PARITY_BIT;
                            rate_d  = BAUD_RELOAD;
                            tx_d    = parity_q;
                        end else begin
                            state_d = STOP;
                            rate_d  = STOP_RELOAD;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        rate_d    = BAUD_RELOAD;
                        bit_cnt_d = bit_cnt_q - BIT_W'(1);
                        tx_d      = shift_q[1];
                    end
                end else begin
                    rate_d = rate_q - RATE_W'(1);
                end
            end
            PARITY_BIT: begin
                if (rate_zero_s) begin
                    state_d = STOP;
                    rate_d  = STOP_RELOAD;
                    tx_d    = 1'b1;
                end else begin
                    rate_d = rate_q - RATE_W'(1);
                end
            end
            STOP: begin
                if (!rate_zero_s) begin
                    rate_d = rate_q - RATE_W'(1);
                end else if (handshake_s) begin
                    // Next word starts straight away: no idle cycle between frames.
                    state_d  = START;
                    rate_d   = BAUD_RELOAD;
                    shift_d  = data_bits;
                    parity_d = uart_parity(par_data_s, PARITY);
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
                end else begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                rate_d    = {RATE_W{1'b0}};
                bit_cnt_d = {BIT_W{1'b0}};
                tx_d      = 1'b1;
                busy_d    = 1'b0;
            end
        endcase
    end

    // State, counters, shift register and registered outputs; reset aborts any frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            rate_q    <= {RATE_W{1'b0}};
            bit_cnt_q <= {BIT_W{1'b0}};
            shift_q   <= {NUMBER_OF_BITS{1'b0}};
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rate_q    <= rate_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign data_ready = ready_s;
    assign tx         = tx_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances with different frame formats, a
// queue-of-line-samples reference model checked every cycle, a bench-side
// receiver that decodes recorded tx traces, and literal expectations.
module tb_uart_tx;

    localparam int NI = 4;
    localparam int TR = 4096;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] valid = 4'b0000;
    logic [3:0] ready_s;
    logic [3:0] tx_s;
    logic [3:0] busy_s;
    logic [8:0] din [NI];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state: an expanded per-cycle line waveform per instance.
    logic frm [NI][256];
    int   pos [NI];
    int   len [NI];
    int   hs_cnt [NI];
    int   hs_cyc [NI];

    logic tr_tx [NI][TR];
    logic tr_bz [NI][TR];
    logic tr_rd [NI][TR];

    initial forever #5 clock = ~clock;

    uart_tx #(.NUMBER_OF_BITS(8), .BAUD_DIVIDER(4), .PARITY(0), .STOP_BITS(1)) u_plain (
        .clock(clock), .reset(reset), .data_valid(valid[0]), .data_ready(ready_s[0]),
        .data_bits(din[0][7:0]), .tx(tx_s[0]), .busy(busy_s[0]));
    uart_tx #(.NUMBER_OF_BITS(8), .BAUD_DIVIDER(4), .PARITY(2), .STOP_BITS(2)) u_even (
        .clock(clock), .reset(reset), .data_valid(valid[1]), .data_ready(ready_s[1]),
        .data_bits(din[1][7:0]), .tx(tx_s[1]), .busy(busy_s[1]));
    uart_tx #(.NUMBER_OF_BITS(8), .BAUD_DIVIDER(4), .PARITY(1), .STOP_BITS(2)) u_odd (
        .clock(clock), .reset(reset), .data_valid(valid[2]), .data_ready(ready_s[2]),
        .data_bits(din[2][7:0]), .tx(tx_s[2]), .busy(busy_s[2]));
    uart_tx #(.NUMBER_OF_BITS(5), .BAUD_DIVIDER(2), .PARITY(0), .STOP_BITS(1)) u_small (
        .clock(clock), .reset(reset), .data_valid(valid[3]), .data_ready(ready_s[3]),
        .data_bits(din[3][4:0]), .tx(tx_s[3]), .busy(busy_s[3]));

    function automatic int nb_of(input int i);
        return (i == 3) ? 5 : 8;
    endfunction
    function automatic int dv_of(input int i);
        return (i == 3) ? 2 : 4;
    endfunction
    function automatic int pm_of(input int i);
        return (i == 1) ? 2 : ((i == 2) ? 1 : 0);
    endfunction
    function automatic int sb_of(input int i);
        return (i == 1 || i == 2) ? 2 : 1;
    endfunction

    // Build the whole line waveform of one frame: bit list, then each bit repeated D times.
    function automatic void build_frame(input int i, input logic [8:0] w);
        logic seq [12];
        int   nbits;
        int   ones;
        int   n;
        logic pb;
        ones  = 0;
        nbits = 0;
        seq[nbits] = 1'b0;
        nbits++;
        for (int b = 0; b < nb_of(i); b++) begin
            seq[nbits] = w[b];
            nbits++;
            if (w[b] === 1'b1) ones++;
        end
        if (pm_of(i) != 0) begin
            pb = ((ones % 2) == 1) ? 1'b1 : 1'b0;
            if (pm_of(i) == 1) pb = ~pb;
            seq[nbits] = pb;
            nbits++;
        end
        for (int s = 0; s < sb_of(i); s++) begin
            seq[nbits] = 1'b1;
            nbits++;
        end
        n = 0;
        for (int b = 0; b < nbits; b++) begin
            for (int k = 0; k < dv_of(i); k++) begin
                frm[i][n] = seq[b];
                n++;
            end
        end
        len[i] = n;
        pos[i] = 0;
    endfunction

    task automatic check(input string name, input int inst, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d cyc=%0d got=%b expected=%b", name, inst, cyc, got, exp);
        end
    endtask

    task automatic checki(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, exp);
        end
    endtask

    // Bench-side receiver: find the start bit, then sample each data bit mid-cell.
    function automatic logic [8:0] rx_decode(input int i, input int from, output int st);
        logic [8:0] w;
        int d;
        w  = 9'h000;
        d  = dv_of(i);
        st = -1;
        for (int c = from; c < from + 400 && c < TR; c++) begin
            if (st < 0 && tr_tx[i][c] === 1'b0) st = c;
        end
        if (st >= 0 && st + (nb_of(i) + 1) * d < TR) begin
            for (int b = 0; b < nb_of(i); b++) begin
                w[b] = tr_tx[i][st + d + b * d + d / 2];
            end
        end
        return w;
    endfunction

    // Model update on each rising edge from the inputs the DUT also samples.
    initial begin
        bit hs;
        for (int i = 0; i < NI; i++) begin
            pos[i] = 0; len[i] = 0; hs_cnt[i] = 0; hs_cyc[i] = 0;
        end
        forever begin
            @(posedge clock);
            cyc++;
            for (int i = 0; i < NI; i++) begin
                if (reset) begin
                    pos[i] = 0;
                    len[i] = 0;
                end else begin
                    hs = (valid[i] === 1'b1) && ((len[i] - pos[i]) <= 1);
                    if (pos[i] < len[i]) pos[i]++;
                    if (hs) begin
                        build_frame(i, din[i]);
                        hs_cnt[i]++;
                        hs_cyc[i] = cyc;
                    end
                end
            end
        end
    end

    // Every-cycle comparison of tx, busy and data_ready against the model.
    initial begin
        logic etx, ebz, erd;
        forever begin
            @(negedge clock);
            if (cyc > 0 && cyc < TR) begin
                for (int i = 0; i < NI; i++) begin
                    etx = (pos[i] < len[i]) ? frm[i][pos[i]] : 1'b1;
                    ebz = (pos[i] < len[i]) ? 1'b1 : 1'b0;
                    erd = (!reset && ((len[i] - pos[i]) <= 1)) ? 1'b1 : 1'b0;
                    tr_tx[i][cyc] = tx_s[i];
                    tr_bz[i][cyc] = busy_s[i];
                    tr_rd[i][cyc] = ready_s[i];
                    check("model_tx", i, tx_s[i], etx);
                    check("model_busy", i, busy_s[i], ebz);
                    check("model_ready", i, ready_s[i], erd);
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic send(input int i, input logic [8:0] w, input bit keep, output int h);
        int base;
        int t;
        base = hs_cnt[i];
        t = 0;
        din[i] = w;
        valid[i] = 1'b1;
        while (hs_cnt[i] == base && t < 200) begin
            @(posedge clock);
            #2;
            t++;
        end
        if (!keep) valid[i] = 1'b0;
        h = hs_cyc[i];
        checks++;
        if (hs_cnt[i] == base) begin
            errors++;
            $display("FAIL handshake_timeout inst=%0d cyc=%0d got=none expected=handshake", i, cyc);
        end
    endtask

    initial begin
        int h, h1, h2, s1, s2, cnt;
        logic [8:0] w;
        logic [9:0] pat55;
        for (int i = 0; i < NI; i++) din[i] = 9'h000;

        // Reset, then the first cycle after release.
        wait_cyc(3);
        check("reset_ready_low", 0, ready_s[0], 1'b0);
        check("reset_tx_high", 0, tx_s[0], 1'b1);
        reset = 1'b0;
        @(negedge clock);
        check("post_reset_ready", 0, ready_s[0], 1'b1);
        check("post_reset_busy", 0, busy_s[0], 1'b0);
        wait_cyc(2);

        // Single frame 0x55: start, 1,0,1,0,1,0,1,0, stop; 4 cycles each.
        pat55 = 10'b1010101010;
        send(0, 9'h055, 1'b0, h);
        wait_cyc(45);
        check("idle_before_start", 0, tr_tx[0][h - 1], 1'b1);
        for (int k = 0; k < 40; k++) check("frame55_tx", 0, tr_tx[0][h + k], pat55[k / 4]);
        check("frame55_ready_c39", 0, tr_rd[0][h + 38], 1'b0);
        check("frame55_ready_c40", 0, tr_rd[0][h + 39], 1'b1);
        check("frame55_busy_last", 0, tr_bz[0][h + 39], 1'b1);
        check("frame55_busy_after", 0, tr_bz[0][h + 40], 1'b0);

        // Back-to-back 0xA5 then 0x3C with valid held high.
        send(0, 9'h0A5, 1'b1, h1);
        send(0, 9'h03C, 1'b0, h2);
        wait_cyc(90);
        checki("b2b_period", h2 - h1, 40);
        w = rx_decode(0, h1 - 2, s1);
        checki("b2b_word1", int'(w), 32'hA5);
        checki("b2b_start1", s1, h1);
        w = rx_decode(0, s1 + 38, s2);
        checki("b2b_word2", int'(w), 32'h3C);
        checki("b2b_start2", s2, h1 + 40);
        cnt = 0;
        for (int k = 0; k < 80; k++) if (tr_bz[0][h1 + k] === 1'b1) cnt++;
        checki("b2b_busy_cycles", cnt, 80);
        check("b2b_busy_end", 0, tr_bz[0][h1 + 80], 1'b0);

        // Parity: 0x07 gives even parity 1, odd parity 0; two stop bits.
        din[2] = 9'h007;
        valid[2] = 1'b1;
        send(1, 9'h007, 1'b0, h);
        valid[2] = 1'b0;
        wait_cyc(55);
        check("even_parity_bit", 1, tr_tx[1][h + 37], 1'b1);
        check("odd_parity_bit", 2, tr_tx[2][h + 37], 1'b0);
        check("odd_parity_end", 2, tr_tx[2][h + 39], 1'b0);
        cnt = 0;
        for (int k = 40; k < 48; k++) if (tr_tx[2][h + k] === 1'b1) cnt++;
        checki("two_stop_high_cycles", cnt, 8);
        check("parity_busy_last", 1, tr_bz[1][h + 47], 1'b1);
        check("parity_busy_after", 1, tr_bz[1][h + 48], 1'b0);
        w = rx_decode(1, h - 2, s1);
        checki("parity_word", int'(w), 32'h07);

        // Backpressure: data changes and valid toggles mid-frame.
        din[1] = 9'h096;
        valid[1] = 1'b1;
        send(0, 9'h096, 1'b0, h);
        valid[1] = 1'b0;
        din[0] = 9'h0FF;
        din[1] = 9'h0FF;
        valid[0] = 1'b1;
        valid[1] = 1'b1;
        wait_cyc(20);
        valid = 4'b0000;
        din[0] = 9'h000;
        din[1] = 9'h000;
        wait_cyc(35);
        w = rx_decode(0, h - 2, s1);
        checki("stable_word_plain", int'(w), 32'h96);
        w = rx_decode(1, h - 2, s1);
        checki("stable_word_parity", int'(w), 32'h96);
        cnt = 0;
        for (int k = 0; k < 39; k++) if (tr_rd[0][h + k] === 1'b1) cnt++;
        checki("no_ready_midframe_plain", cnt, 0);
        cnt = 0;
        for (int k = 0; k < 40; k++) if (tr_rd[1][h + k] === 1'b1) cnt++;
        checki("no_ready_midframe_parity", cnt, 0);

        // Reset during data bit 3 of 0x00, then a clean frame.
        send(0, 9'h000, 1'b0, h);
        wait_cyc(17);
        reset = 1'b1;
        wait_cyc(1);
        reset = 1'b0;
        @(negedge clock);
        check("abort_tx_high", 0, tx_s[0], 1'b1);
        check("abort_busy_low", 0, busy_s[0], 1'b0);
        check("bit3_was_low", 0, tr_tx[0][h + 17], 1'b0);
        wait_cyc(1);
        send(0, 9'h0C3, 1'b0, h);
        wait_cyc(45);
        w = rx_decode(0, h - 2, s1);
        checki("after_reset_word", int'(w), 32'hC3);
        checki("after_reset_start", s1, h);

        // Narrow edge parameters: N=5, D=2, 0x1F -> 0,1,1,1,1,1,1.
        send(3, 9'h01F, 1'b0, h);
        wait_cyc(20);
        for (int k = 0; k < 14; k++) check("small_tx", 3, tr_tx[3][h + k], (k < 2) ? 1'b0 : 1'b1);
        check("small_ready_c13", 3, tr_rd[3][h + 12], 1'b0);
        check("small_ready_c14", 3, tr_rd[3][h + 13], 1'b1);
        check("small_busy_last", 3, tr_bz[3][h + 13], 1'b1);
        check("small_busy_after", 3, tr_bz[3][h + 14], 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Asynchronous serial transmitter, the transmit-side counterpart of the team's UART receiver. It accepts one data word per valid/ready handshake, serialises it LSB first, and drives a registered `tx` line. The frame is a start bit, the data bits, an optional parity bit, and one or two stop bits. It sits between an internal stream source (FIFO, command encoder) and the pad, and frames are bit-compatible with `uart_rx` built with the same `NUMBER_OF_BITS`/`BAUD_DIVIDER`.

## Interface
Parameters:
- `NUMBER_OF_BITS`, 8: data bits per frame, 5..9.
- `BAUD_DIVIDER`, 4: clock cycles per bit, ≥2.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.

Ports:
- `clock` in 1: single clock domain.
- `reset` in 1: synchronous, active-high.
- `data_valid` in 1: source offers `data_bits`.
- `data_ready` out 1: transmitter accepts a word this cycle.
- `data_bits` in `NUMBER_OF_BITS`: word to send, bit 0 first.
- `tx` out 1: serial line, idle high, registered.
- `busy` out 1: high from the cycle after acceptance through the last stop-bit cycle.

## Operation
- State machine, with states from `uart_pkg::uart_tx_state_t`: IDLE, START, DATA, PARITY_BIT, STOP.
- A handshake completes when `data_valid && data_ready` on a rising edge. The word is latched into the shift register at that edge. Parity is computed at the same edge: odd parity = ~^data, even parity = ^data.
- IDLE:
  - `tx`=1, `data_ready`=1.
  - On handshake, go to START and load `rate_counter` = `BAUD_DIVIDER-1`.
- START:
  - `tx`=0 for `BAUD_DIVIDER` cycles.
  - Then go to DATA with `bit_counter` = `NUMBER_OF_BITS-1`.
- DATA:
  - `tx` = shift register bit 0.
  - Each time `rate_counter` reaches 0: shift right, reload the counter, decrement `bit_counter`.
  - After the bit where `bit_counter` = 0, go to PARITY_BIT if `PARITY`≠0, else STOP.
- PARITY_BIT:
  - `tx` = the latched parity bit, held for `BAUD_DIVIDER` cycles.
- STOP:
  - `tx`=1 for `STOP_BITS*BAUD_DIVIDER` cycles.
  - On the final cycle, `data_ready`=1. On a handshake in that cycle, go directly to START, which gives gapless back-to-back frames. Otherwise go to IDLE.
- `data_ready` is combinational from state/counters and does not depend on `data_valid`. It is 0 in START, DATA and PARITY_BIT, and 0 while `reset` is high.
- `data_bits` is sampled only at the handshake edge. Changes to it mid-frame have no effect.
- Counter widths:
  - `rate_counter`: `$clog2(STOP_BITS*BAUD_DIVIDER)`, minimum 1.
  - `bit_counter`: `$clog2(NUMBER_OF_BITS)`, minimum 1.
  - Both count down. No wrap is permitted: reload occurs at 0.
- Reset mid-frame aborts immediately. The next cycle has `tx`=1, IDLE state and `busy`=0. No partial frame resumes.

## Timing
- Reset values: `tx`=1, `busy`=0, state IDLE, counters 0. `data_ready`=0 during reset, and 1 in the first cycle after reset deasserts.
- Latency: the `tx` falling edge of the start bit appears 1 cycle after the handshake edge. `tx` is a flop, so there are no glitches.
- Frame length is exactly (1 + `NUMBER_OF_BITS` + (`PARITY`≠0) + `STOP_BITS`) × `BAUD_DIVIDER` cycles. With back-to-back handshakes the frame period equals the frame length.
- `busy` rises with the start bit and falls the cycle after the last stop-bit cycle, unless a new frame starts in that cycle.

## Structure
- `uart_pkg`:
  - `uart_tx_state_t` enum.
  - Parity constants `UART_PARITY_NONE/ODD/EVEN`.
  - A `uart_parity(data, mode)` function, shared with a future parity-aware `uart_rx`.
- No sub-module. Baud and bit counters are inline; one always_ff holds the state, counters, shift register and `tx`.
- Elaboration-time assertions check the legal ranges of `PARITY`, `STOP_BITS`, `BAUD_DIVIDER` and `NUMBER_OF_BITS`.

## Test plan
- **Single frame.** N=8, D=4, no parity, 1 stop bit; send 0x55.
  - `tx`: 4 cycles 0, then 1,0,1,0,1,0,1,0, each 4 cycles, then 4 cycles 1.
  - `data_ready` returns in cycle 40 after the handshake.
- **Back-to-back.** Hold `data_valid` high; send 0xA5 then 0x3C.
  - The second start bit begins immediately after the first stop bit: 80 cycles total, no idle gap.
  - Both words are decoded correctly by a bench-side `uart_rx` loopback.
- **Parity.** `PARITY`=2 with 0x07 gives parity bit 1; `PARITY`=1 with 0x07 gives parity bit 0.
  - `STOP_BITS`=2 gives 8 high stop cycles.
  - Frame length is 48 cycles.
- **Backpressure and stability.** Change `data_bits` mid-frame and drop `data_valid` mid-frame.
  - The transmitted word is unchanged.
  - `data_ready` is never high in START, DATA or PARITY_BIT.
- **Reset mid-frame.** Assert `reset` during data bit 3 of 0x00.
  - The next cycle has `tx`=1 and `busy`=0.
  - The next handshake produces a complete, correct frame.
- **Edge parameters.** N=5, D=2, send 0x1F: frame is 14 cycles with `tx` pattern 0,1,1,1,1,1,1 (each 2 cycles).
